breath_pwm: RTL and testbench

Consumer end of the color sequencer interface: samples the 3-bit color code from `fsm` and turns it into three PWM-driven LED channels with a triangular "breathing" brightness envelope. It sits between `fsm` (`color_o` → `color_i`) and the board RGB LED pins. A new color is accepted only at the dark point of each breath, so every color change is invisible.

---
 rtl/breath_pwm.sv | 176 +++++++++++++++++
 tb/tb_breath_pwm.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/breath_pwm.sv
// RGB breathing-LED driver: latches a color code at the dark point of each breath
// and drives three PWM channels scaled by a triangular envelope. Option: BREATH_GAMMA_EN.

`ifndef RED
`define RED    3'd1
`define ORANGE 3'd2
`define YELLOW 3'd3
`define GREEN  3'd4
`define BLUE   3'd5
`define PURPLE 3'd6
`endif

module breath_pwm #(
    parameter int STEP_DIV   = 1024,
    parameter int HOLD_STEPS = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] color_i,
    output logic       led_r_o,
    output logic       led_g_o,
    output logic       led_b_o,
    output logic [7:0] bright_o,
    output logic       color_ack_o,
    output logic       cycle_done_o
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_STEPS - 1);

    typedef enum logic [1:0] {
        LOAD,
        RISE,
        TOP,
        FALL
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [7:0]      pwm_cnt;
    logic [7:0]      bright, bright_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [2:0]      color_q, color_n;
    logic            ack_n, done_n;
    logic [7:0]      bright_eff;
    logic [7:0]      tgt_r, tgt_g, tgt_b;
    logic [7:0]      level_r, level_g, level_b;

    function automatic logic [7:0] scale(input logic [7:0] a, input logic [7:0] b);
        return 8'((16'(a) * 16'(b)) >> 8);
    endfunction

    always_comb begin
        tick = (presc == PRESC_LAST);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= LOAD;
            bright       <= '0;
            hold_cnt     <= '0;
            color_q      <= '0;
            color_ack_o  <= 1'b0;
            cycle_done_o <= 1'b0;
        end else begin
            state        <= state_n;
            bright       <= bright_n;
            hold_cnt     <= hold_n;
            color_q      <= color_n;
            color_ack_o  <= ack_n;
            cycle_done_o <= done_n;
        end
    end

    // Every state change and envelope step is gated by the prescaler tick.
    always_comb begin
        state_n  = state;
        bright_n = bright;
        hold_n   = hold_cnt;
        color_n  = color_q;
        ack_n    = 1'b0;
        done_n   = 1'b0;
        if (tick) begin
            case (state)
                LOAD: begin
                    color_n = color_i;
                    ack_n   = 1'b1;
                    state_n = RISE;
                end
                RISE: begin
                    if (bright == 8'd254) begin
                        bright_n = 8'd255;
                        hold_n   = '0;
                        state_n  = TOP;
                    end else begin
                        bright_n = bright + 8'd1;
                    end
                end
                TOP: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = FALL;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                FALL: begin
                    if (bright == 8'd1) begin
                        bright_n = 8'd0;
                        done_n   = 1'b1;
                        state_n  = LOAD;
                    end else begin
                        bright_n = bright - 8'd1;
                    end
                end
                default: state_n = LOAD;
            endcase
        end
    end

    always_comb begin
        bright_o = bright;
`ifdef BREATH_GAMMA_EN
        bright_eff = scale(bright, bright);
`else
        bright_eff = bright;
`endif
    end

    // Unknown codes decode to black so the breath still runs, just dark.
    always_comb begin
        tgt_r = '0;
        tgt_g = '0;
        tgt_b = '0;
        case (color_q)
            `RED:    begin tgt_r = 8'd255;                                   end
            `ORANGE: begin tgt_r = 8'd255; tgt_g = 8'd128;                   end
            `YELLOW: begin tgt_r = 8'd255; tgt_g = 8'd255;                   end
            `GREEN:  begin                 tgt_g = 8'd255;                   end
            `BLUE:   begin                                  tgt_b = 8'd255;  end
            `PURPLE: begin tgt_r = 8'd128;                  tgt_b = 8'd255;  end
            default: begin                                                   end
        endcase
    end

    always_comb begin
        level_r = scale(tgt_r, bright_eff);
        level_g = scale(tgt_g, bright_eff);
        level_b = scale(tgt_b, bright_eff);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            led_r_o <= 1'b0;
            led_g_o <= 1'b0;
            led_b_o <= 1'b0;
        end else begin
            led_r_o <= (pwm_cnt < level_r);
            led_g_o <= (pwm_cnt < level_g);
            led_b_o <= (pwm_cnt < level_b);
        end
    end

endmodule

// File: tb/tb_breath_pwm.sv
// Scoreboard bench for breath_pwm: expected ack/done pulses are queued with their
// cycle stamps and checked by an independent monitor; levels checked directly.

`ifndef RED
`define RED    3'd1
`define ORANGE 3'd2
`define YELLOW 3'd3
`define GREEN  3'd4
`define BLUE   3'd5
`define PURPLE 3'd6
`endif

module tb_breath_pwm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] color = 3'b101;
    logic       led_r, led_g, led_b, ack, done;
    logic [7:0] bright;

    logic       rst2 = 1'b1;
    logic [2:0] color2 = `RED;
    logic       led_r2, led_g2, led_b2, ack2, done2;
    logic [7:0] bright2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int cyc2  = 0;
    int r_cnt, g_cnt, b_cnt;

    typedef struct {
        bit is_ack;
        int at;
    } ev_t;
    ev_t sb[$];
    ev_t ev;

    always #5 clk = ~clk;

    breath_pwm #(.STEP_DIV(4), .HOLD_STEPS(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .color_i(color),
        .led_r_o(led_r), .led_g_o(led_g), .led_b_o(led_b),
        .bright_o(bright), .color_ack_o(ack), .cycle_done_o(done)
    );

    // Long TOP phase so a full 256-clock PWM period fits at constant brightness.
    breath_pwm #(.STEP_DIV(2), .HOLD_STEPS(200)) u_top (
        .clk_i(clk), .rst_i(rst2), .color_i(color2),
        .led_r_o(led_r2), .led_g_o(led_g2), .led_b_o(led_b2),
        .bright_o(bright2), .color_ack_o(ack2), .cycle_done_o(done2)
    );

    always @(posedge clk) cyc  = rst  ? 0 : cyc + 1;
    always @(posedge clk) cyc2 = rst2 ? 0 : cyc2 + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit is_ack, input int at);
        ev_t e;
        e.is_ack = is_ack;
        e.at     = at;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ack || done) begin
            n_cmp++;
            if (ack && done) begin
                n_err++;
                $display("FAIL pulse_overlap: ack=1 done=1 at cyc %0d, expected never both", cyc);
            end else if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: ack=%0d done=%0d at cyc %0d, expected none", ack, done, cyc);
            end else begin
                ev = sb.pop_front();
                if (ev.is_ack != ack || ev.at != cyc) begin
                    n_err++;
                    $display("FAIL pulse: ack=%0d at cyc %0d, expected ack=%0d at cyc %0d",
                             ack, cyc, ev.is_ack, ev.at);
                end
            end
        end
    end

    task automatic run_to(input int target);
        int guard = 0;
        while (cyc != target && guard < 5000) begin
            @(negedge clk);
            r_cnt += int'(led_r);
            g_cnt += int'(led_g);
            b_cnt += int'(led_b);
            guard++;
        end
        if (cyc != target) check("run_to_timeout", cyc, target);
    endtask

    task automatic run2_to(input int target);
        int guard = 0;
        while (cyc2 != target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc2 != target) check("run2_to_timeout", cyc2, target);
    endtask

    task automatic clr_cnt();
        r_cnt = 0;
        g_cnt = 0;
        b_cnt = 0;
    endtask

    task automatic hold_window(input logic [2:0] c, input int er, input int eg, input int eb,
                               input string tag);
        int r = 0, g = 0, b = 0;
        color2 = c;
        rst2   = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        run2_to(2);
        check({tag, "_ack2"}, int'(ack2), 1);
        run2_to(513);
        check({tag, "_bright_top"}, int'(bright2), 255);
        repeat (256) begin
            @(negedge clk);
            r += int'(led_r2);
            g += int'(led_g2);
            b += int'(led_b2);
        end
        check({tag, "_r_highs"}, r, er);
        check({tag, "_g_highs"}, g, eg);
        check({tag, "_b_highs"}, b, eb);
        rst2 = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr_cnt();
        repeat (3) begin
            @(negedge clk);
            check("reset_pins", int'({led_r, led_g, led_b, ack, done}), 0);
            check("reset_bright", int'(bright), 0);
        end

        // Breath 1: RED, switch to BLUE mid-RISE (must be ignored until next LOAD).
        color = `RED;
        rst   = 1'b0;
        push(1'b1, 4);
        push(1'b0, 2052);
        push(1'b1, 2056);
        clr_cnt();
        run_to(500);
        check("bright_rise_t125", int'(bright), 124);
        color = `BLUE;
        run_to(1023);
        check("bright_254", int'(bright), 254);
        run_to(1024);
        check("bright_255", int'(bright), 255);
        run_to(2051);
        check("bright_fall_end", int'(bright), 1);
        run_to(2052);
        check("bright_dark", int'(bright), 0);
        run_to(2056);
        check("b1_green_highs", g_cnt, 0);
        check("b1_blue_highs", b_cnt, 0);
        check("b1_red_active", int'(r_cnt > 0), 1);

        // Breath 2: BLUE, reset mid-FALL at bright 100.
        clr_cnt();
        run_to(3704);
        check("bright_mid_fall", int'(bright), 100);
        check("b2_red_highs", r_cnt, 0);
        check("b2_green_highs", g_cnt, 0);
        check("b2_blue_active", int'(b_cnt > 0), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_bright", int'(bright), 0);
        check("midreset_pins", int'({led_r, led_g, led_b, ack, done}), 0);
        check("sb_empty_at_reset", sb.size(), 0);

        // Breath 3: undefined code gives a dark breath with normal pulse timing.
        rst   = 1'b0;
        color = 3'b111;
        push(1'b1, 4);
        push(1'b0, 2052);
        push(1'b1, 2056);
        clr_cnt();
        run_to(1024);
        check("dark_bright_255", int'(bright), 255);
        run_to(2060);
        check("dark_led_highs", r_cnt + g_cnt + b_cnt, 0);
        check("sb_drained", sb.size(), 0);

        // Full-brightness PWM duty over one 256-clock period.
`ifdef BREATH_GAMMA_EN
        hold_window(`RED,    253, 0,   0, "red");
        hold_window(`ORANGE, 253, 127, 0, "orange");
`else
        hold_window(`RED,    254, 0,   0, "red");
        hold_window(`ORANGE, 254, 127, 0, "orange");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
